mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Sequencer for an unsigned shift-and-add multiplier.
- Captures two operands on a start request and runs exactly WIDTH add/shift iterations, paced by an internal down-counter loaded with WIDTH and decremented to 0.
- Presents the 2*WIDTH-bit product with a done/ack handshake.
- Sits between the lab top-level (switch/test driver) and the product display/consumer.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..16.
- CW, 4, iteration counter width; must satisfy 2**CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  multiplicand; sampled on the accepting start edge
- b_in  input  WIDTH  multiplier; sampled on the accepting start edge
- ack  input  1  consumer acknowledge; sampled only in DONE
- busy  output  1  high in LOAD and RUN
- done  output  1  high in DONE
- product  output  2*WIDTH  result register
- count  output  CW  iterations remaining

Behaviour:
- Reset is synchronous: at a rising edge with reset=1, state=IDLE and product=0, count=0, busy=0, done=0, all internal registers=0. Reset has priority over all other inputs and aborts any operation in progress; no partial result survives.
- States: IDLE, LOAD, RUN, DONE. State is registered; busy and done decode from state with no combinational path from inputs.
- IDLE:
  - start=1 at an edge: capture a_in and b_in into operand registers, go to LOAD.
  - start=0: stay in IDLE; product holds its last value.
- LOAD (1 cycle):
  - mcand <= {WIDTH'0, A}, mplier <= B, product <= 0, count <= WIDTH.
  - Go to RUN.
- RUN, one iteration per cycle:
  - If mplier[0]=1, product <= product + mcand. Addition is modulo 2**(2*WIDTH) and cannot overflow for unsigned operands.
  - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count - 1.
  - On the edge where count==1, count becomes 0 and state goes to DONE. RUN therefore lasts exactly WIDTH cycles (WIDTH=1 gives one RUN cycle).
- Latency: the start edge is edge 0. LOAD occupies cycle 1, RUN occupies cycles 2..WIDTH+1, and done is first high in cycle WIDTH+2 (cycle 10 for WIDTH=8).
- DONE:
  - product and count=0 are held stable.
  - ack=1 at an edge: go to IDLE; done falls the next cycle.
  - start is ignored in DONE.
  - ack and start both high in DONE: ack is honoured, start is ignored. A new start must be presented in IDLE.
- start asserted while busy is ignored and has no effect on operands.
- ack outside DONE is ignored.
- count never wraps; it is not decremented outside RUN.
- Operands of 0 run the full WIDTH cycles and produce product=0.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: in RUN, if the multiplier register shifted this cycle (mplier>>1) is zero, the state goes to DONE after the current iteration regardless of count. count then holds its residual nonzero value in DONE, which exposes how many iterations were skipped. product is identical to the non-early result.
- Not defined: RUN always lasts exactly WIDTH cycles, as described above.

Test Plan:
- WIDTH=8: reset, start with a_in=13, b_in=11 -> busy high for 9 cycles (1 LOAD + 8 RUN), done in cycle 10, product=143, count=0. ack -> IDLE, done low next cycle.
- a_in=255, b_in=255 -> product=65025 (16'hFE01). Repeat with a_in=0, b_in=200 -> product=0 after the full 8 RUN cycles.
- start held high through the whole op while a_in/b_in change every cycle -> product reflects only the operands at the accepting edge. DONE holds until ack; ack with start=1 -> IDLE, then a new op starts from IDLE.
- reset=1 asserted in the 4th RUN cycle -> next cycle state=IDLE, product=0, count=0, busy=0, done=0. A following op (7 x 9) gives 63.
- WIDTH=1 build: a_in=1, b_in=1 -> exactly one RUN cycle, product=1. ack pulsed in IDLE and start pulsed in RUN have no effect.
- MULT_EARLY_TERM_EN defined, WIDTH=8, a_in=5, b_in=3 -> 2 RUN cycles, done in cycle 4, product=15, count=6. Without the macro -> done in cycle 10, product=15, count=0.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Sequencer for an unsigned shift-and-add multiplier: IDLE -> LOAD -> RUN (WIDTH iterations) -> DONE.
// Optional early termination when the remaining multiplier bits are all zero: define MULT_EARLY_TERM_EN.
module mult_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 ack,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [CW-1:0]        count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_product;
    logic [CW-1:0]        r_count;
    logic [WIDTH-1:0]     w_mplier_shr;
    logic                 w_last_iter;

    assign w_mplier_shr = r_mplier >> 1;

`ifdef MULT_EARLY_TERM_EN
    // Stop once no set multiplier bits remain; count keeps the skipped-iteration residue.
    assign w_last_iter = (r_count == CW'(1)) || (w_mplier_shr == '0);
`else
    assign w_last_iter = (r_count == CW'(1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy         = 1'b1;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last_iter) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a <= a_in;
                        r_b <= b_in;
                    end
                end
                S_LOAD: begin
                    r_mcand   <= {{WIDTH{1'b0}}, r_a};
                    r_mplier  <= r_b;
                    r_product <= '0;
                    r_count   <= CW'(WIDTH);
                end
                S_RUN: begin
                    if (r_mplier[0]) begin
                        r_product <= r_product + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shr;
                    r_count  <= r_count - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;
    assign count   = r_count;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed testbench for mult_seq_ctrl: a WIDTH=8 instance plus a WIDTH=1 instance.
// Expectations adapt when MULT_EARLY_TERM_EN is defined.
module tb_mult_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        ack;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [3:0]  count;

    logic        start1;
    logic [0:0]  a1;
    logic [0:0]  b1;
    logic        ack1;
    logic        busy1;
    logic        done1;
    logic [1:0]  product1;
    logic [0:0]  count1;

    int n_tests;
    int n_fail;

    mult_seq_ctrl #(.WIDTH(8), .CW(4)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .ack     (ack),
        .busy    (busy),
        .done    (done),
        .product (product),
        .count   (count)
    );

    mult_seq_ctrl #(.WIDTH(1), .CW(1)) u_dut_w1 (
        .clk     (clk),
        .reset   (reset),
        .start   (start1),
        .a_in    (a1),
        .b_in    (b1),
        .ack     (ack1),
        .busy    (busy1),
        .done    (done1),
        .product (product1),
        .count   (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full operation; hold_start keeps start high with changing operands throughout.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_prod, input bit hold_start);
        int runs;
        int cyc;
        int nb;
`ifdef MULT_EARLY_TERM_EN
        runs = 1;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) runs = i + 1;
        end
`else
        runs = 8;
`endif
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        ack   = 1'b0;
        tick();
        start = hold_start;
        cyc = 1;
        nb  = 0;
        while (!done && cyc < 40) begin
            if (busy) nb++;
            if (hold_start) begin
                a_in = 8'($urandom);
                b_in = 8'($urandom);
            end
            tick();
            cyc++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("done_cycle", cyc, runs + 2);
        check("busy_cycles", nb, runs + 1);
        check("product", {16'd0, product}, {16'd0, exp_prod});
        check("count_done", {28'd0, count}, 32'(8 - runs));
        for (int k = 0; k < 2; k++) begin
            if (hold_start) begin
                a_in = 8'($urandom);
                b_in = 8'($urandom);
            end
            tick();
        end
        check("done_hold", {31'd0, done}, 32'd1);
        check("product_hold", {16'd0, product}, {16'd0, exp_prod});
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("done_after_ack", {31'd0, done}, 32'd0);
        check("busy_after_ack", {31'd0, busy}, 32'd0);
        check("product_idle", {16'd0, product}, {16'd0, exp_prod});
        $display("[TB] op %0d x %0d -> product %0d in cycle %0d", a, b, product, cyc);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; ack = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; ack1 = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        run_op(8'd13,  8'd11,  16'd143,   1'b0);
        run_op(8'd255, 8'd255, 16'hFE01,  1'b0);
        run_op(8'd0,   8'd200, 16'd0,     1'b0);
        run_op(8'd5,   8'd3,   16'd15,    1'b0);
        run_op(8'd6,   8'd7,   16'd42,    1'b1);
        // start was still high through the ack edge; a fresh op must begin from IDLE.
        run_op(8'd12,  8'd10,  16'd120,   1'b0);

        // Reset during the 4th RUN cycle (cycle 5 after the start edge).
        a_in = 8'd100; b_in = 8'd77; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        check("mid_count", {28'd0, count}, 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_product", {16'd0, product}, 32'd0);
        check("abort_count", {28'd0, count}, 32'd0);
        $display("[TB] reset abort of 100 x 77 -> product %0d", product);
        run_op(8'd7, 8'd9, 16'd63, 1'b0);

        // WIDTH=1 instance: ack in IDLE and start in RUN are ignored.
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        check("w1_idle_busy", {31'd0, busy1}, 32'd0);
        check("w1_idle_done", {31'd0, done1}, 32'd0);
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1_load_busy", {31'd0, busy1}, 32'd1);
        tick();
        check("w1_run_busy", {31'd0, busy1}, 32'd1);
        a1 = 1'b0; b1 = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1_done", {31'd0, done1}, 32'd1);
        check("w1_product", {30'd0, product1}, 32'd1);
        check("w1_count", {31'd0, count1}, 32'd0);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        check("w1_done_after_ack", {31'd0, done1}, 32'd0);
        check("w1_product_idle", {30'd0, product1}, 32'd1);
        $display("[TB] w1 op 1 x 1 -> product %0d", product1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
